// File: rtl/osd_label_multi.sv
// Multi-channel OSD label address generator: up to NUM_CH labels above their boxes, 3-cycle pipeline.
// Optional build macro OSD_FRAME_LATCH_EN latches box_x/box_y/ch_en on each frame start.
module osd_label_multi #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned OSD_WIDTH  = 144,
    parameter int unsigned OSD_HEIGHT = 28,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                    pixelclk,
    input  logic                    reset,
    input  logic                    i_vsync,
    input  logic [CNT_W-1:0]        hcount,
    input  logic [CNT_W-1:0]        vcount,
    input  logic [NUM_CH*CNT_W-1:0] box_x,
    input  logic [NUM_CH*CNT_W-1:0] box_y,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic                    region_active,
    output logic [2:0]              ch_id,
    output logic [CNT_W-1:0]        osd_x,
    output logic [CNT_W-1:0]        osd_y,
    output logic [ADDR_W-1:0]       osd_ram_addr
);

    localparam int unsigned EXT_W      = CNT_W + 1;
    localparam int unsigned LABEL_SIZE = OSD_WIDTH * OSD_HEIGHT;

    logic vsync_d0;
    logic vsync_d1;
    logic frame_start;

    // Two-flop vsync history; frame start is the falling edge
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
        end else begin
            vsync_d0 <= i_vsync;
            vsync_d1 <= vsync_d0;
        end
    end

    assign frame_start = vsync_d1 & ~vsync_d0;

    logic [NUM_CH*CNT_W-1:0] cur_x;
    logic [NUM_CH*CNT_W-1:0] cur_y;
    logic [NUM_CH-1:0]       cur_en;

`ifdef OSD_FRAME_LATCH_EN
    // Shadow copies so a label cannot move mid-frame
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            cur_x  <= '0;
            cur_y  <= '0;
            cur_en <= '0;
        end else if (frame_start) begin
            cur_x  <= box_x;
            cur_y  <= box_y;
            cur_en <= ch_en;
        end
    end
`else
    logic unused_frame_start;

    assign cur_x              = box_x;
    assign cur_y              = box_y;
    assign cur_en             = ch_en;
    assign unused_frame_start = frame_start;
`endif

    logic [NUM_CH-1:0][CNT_W-1:0] bx_c;
    logic [NUM_CH-1:0][CNT_W-1:0] top_c;
    logic [NUM_CH-1:0][EXT_W-1:0] right_c;
    logic [NUM_CH-1:0][EXT_W-1:0] bottom_c;
    logic [NUM_CH-1:0]            hit_c;
    logic [NUM_CH-1:0][CNT_W-1:0] off_x_c;
    logic [NUM_CH-1:0][CNT_W-1:0] off_y_c;

    // Per-channel rectangle test; edges widened so nothing past the counter range wraps
    always_comb begin
        bx_c     = '0;
        top_c    = '0;
        right_c  = '0;
        bottom_c = '0;
        hit_c    = '0;
        off_x_c  = '0;
        off_y_c  = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            bx_c[k]     = cur_x[k*CNT_W +: CNT_W];
            top_c[k]    = (cur_y[k*CNT_W +: CNT_W] >= CNT_W'(OSD_HEIGHT))
                        ? cur_y[k*CNT_W +: CNT_W] - CNT_W'(OSD_HEIGHT) : '0;
            right_c[k]  = EXT_W'(bx_c[k]) + EXT_W'(OSD_WIDTH - 1);
            bottom_c[k] = EXT_W'(top_c[k]) + EXT_W'(OSD_HEIGHT - 1);
            hit_c[k]    = cur_en[k]
                        && (hcount >= bx_c[k]) && (EXT_W'(hcount) <= right_c[k])
                        && (vcount >= top_c[k]) && (EXT_W'(vcount) <= bottom_c[k]);
            off_x_c[k]  = hcount - bx_c[k];
            off_y_c[k]  = vcount - top_c[k];
        end
    end

    logic [NUM_CH-1:0]            s1_hit;
    logic [NUM_CH-1:0][CNT_W-1:0] s1_off_x;
    logic [NUM_CH-1:0][CNT_W-1:0] s1_off_y;

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            s1_hit   <= '0;
            s1_off_x <= '0;
            s1_off_y <= '0;
        end else begin
            s1_hit   <= hit_c;
            s1_off_x <= off_x_c;
            s1_off_y <= off_y_c;
        end
    end

    logic             win_hit_c;
    logic [2:0]       win_id_c;
    logic [CNT_W-1:0] win_x_c;
    logic [CNT_W-1:0] win_y_c;

    // Fixed priority: scanning downward lets the lowest hitting index overwrite last
    always_comb begin
        win_hit_c = 1'b0;
        win_id_c  = '0;
        win_x_c   = '0;
        win_y_c   = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            if (s1_hit[k]) begin
                win_hit_c = 1'b1;
                win_id_c  = 3'(k);
                win_x_c   = s1_off_x[k];
                win_y_c   = s1_off_y[k];
            end
        end
    end

    logic             s2_hit;
    logic [2:0]       s2_id;
    logic [CNT_W-1:0] s2_x;
    logic [CNT_W-1:0] s2_y;

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            s2_hit <= 1'b0;
            s2_id  <= '0;
            s2_x   <= '0;
            s2_y   <= '0;
        end else begin
            s2_hit <= win_hit_c;
            s2_id  <= win_id_c;
            s2_x   <= win_x_c;
            s2_y   <= win_y_c;
        end
    end

    logic [ADDR_W-1:0] addr_c;

    // Banked address; all terms are zero when nothing hits
    assign addr_c = ADDR_W'(s2_id) * ADDR_W'(LABEL_SIZE)
                  + ADDR_W'(s2_y) * ADDR_W'(OSD_WIDTH)
                  + ADDR_W'(s2_x);

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            region_active <= 1'b0;
            ch_id         <= '0;
            osd_x         <= '0;
            osd_y         <= '0;
            osd_ram_addr  <= '0;
        end else begin
            region_active <= s2_hit;
            ch_id         <= s2_id;
            osd_x         <= s2_x;
            osd_y         <= s2_y;
            osd_ram_addr  <= addr_c;
        end
    end

endmodule

// File: tb/tb_osd_label_multi.sv
// Scoreboard bench for osd_label_multi: directed pixels with hand-computed expectations.
module tb_osd_label_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned ADDR_W = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    i_vsync;
    logic [CNT_W-1:0]        hcount;
    logic [CNT_W-1:0]        vcount;
    logic [NUM_CH*CNT_W-1:0] box_x;
    logic [NUM_CH*CNT_W-1:0] box_y;
    logic [NUM_CH-1:0]       ch_en;
    logic                    region_active;
    logic [2:0]              ch_id;
    logic [CNT_W-1:0]        osd_x;
    logic [CNT_W-1:0]        osd_y;
    logic [ADDR_W-1:0]       osd_ram_addr;

    osd_label_multi dut (
        .pixelclk      (clk),
        .reset         (reset),
        .i_vsync       (i_vsync),
        .hcount        (hcount),
        .vcount        (vcount),
        .box_x         (box_x),
        .box_y         (box_y),
        .ch_en         (ch_en),
        .region_active (region_active),
        .ch_id         (ch_id),
        .osd_x         (osd_x),
        .osd_y         (osd_y),
        .osd_ram_addr  (osd_ram_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic             act;
        logic [2:0]       id;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic [ADDR_W-1:0] addr;
        string            tag;
    } exp_t;

    exp_t     q[$];
    exp_t     e_m;
    int       cyc      = 0;
    int       errors   = 0;
    int       checks   = 0;
    logic     end_chk  = 1'b0;
    logic [2:0] rst_hist = 3'b111;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_hist <= {rst_hist[1:0], reset};
    end

    // Monitor: any reset among the last three edges forces an all-zero result
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            e_m = q.pop_front();
            checks++;
            if (rst_hist != 3'b000) begin
                e_m.act  = 1'b0;
                e_m.id   = '0;
                e_m.x    = '0;
                e_m.y    = '0;
                e_m.addr = '0;
            end
            if (e_m.due != cyc || region_active !== e_m.act || ch_id !== e_m.id ||
                osd_x !== e_m.x || osd_y !== e_m.y || osd_ram_addr !== e_m.addr) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d: got act=%0b id=%0d x=%0d y=%0d addr=%0d, required act=%0b id=%0d x=%0d y=%0d addr=%0d",
                         e_m.tag, cyc, e_m.due, region_active, ch_id, osd_x, osd_y, osd_ram_addr,
                         e_m.act, e_m.id, e_m.x, e_m.y, e_m.addr);
            end
        end
        if (end_chk) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d entries pending, required 0", q.size());
            end
        end
    end

    task automatic pix(input int h, input int v, input logic act, input int id,
                       input int x, input int y, input int addr, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        hcount = CNT_W'(h);
        vcount = CNT_W'(v);
        e.due  = cyc + 3;
        e.act  = act;
        e.id   = 3'(id);
        e.x    = CNT_W'(x);
        e.y    = CNT_W'(y);
        e.addr = ADDR_W'(addr);
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic idle();
        pix(0, 4095, 1'b0, 0, 0, 0, 0, "idle");
    endtask

    task automatic set_ch(input int k, input int bx, input int by, input logic en);
        box_x[k*CNT_W +: CNT_W] = CNT_W'(bx);
        box_y[k*CNT_W +: CNT_W] = CNT_W'(by);
        ch_en[k]                = en;
    endtask

    task automatic frame();
        i_vsync = 1'b1;
        idle();
        idle();
        i_vsync = 1'b0;
        repeat (4) idle();
    endtask

    task automatic miss(input int h, input int v, input string tag);
        pix(h, v, 1'b0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        reset   = 1'b1;
        i_vsync = 1'b0;
        hcount  = '0;
        vcount  = CNT_W'(4095);
        box_x   = '0;
        box_y   = '0;
        ch_en   = '0;
        repeat (4) idle();
        reset = 1'b0;
        repeat (3) idle();

        // Single label at box (100,200): label rows 172..199, cols 100..243
        idle();
        set_ch(0, 100, 200, 1'b1);
        frame();
        pix(100, 172, 1'b1, 0, 0, 0, 0, "t1_origin");
        pix(243, 199, 1'b1, 0, 143, 27, 4031, "t1_far_corner");
        miss(244, 199, "t1_right_out");
        miss(99, 172, "t1_left_out");
        miss(100, 171, "t1_top_out");
        miss(100, 200, "t1_bottom_out");
        pix(150, 180, 1'b1, 0, 50, 8, 1202, "t1_mid");

        // Overlap of ch1/ch2 at box (50,60): lowest index wins
        idle();
        set_ch(0, 100, 200, 1'b0);
        set_ch(1, 50, 60, 1'b1);
        set_ch(2, 50, 60, 1'b1);
        frame();
        pix(60, 40, 1'b1, 1, 10, 8, 5194, "t2_ch1_wins");
        idle();
        set_ch(1, 50, 60, 1'b0);
        frame();
        pix(60, 40, 1'b1, 2, 10, 8, 9226, "t2_ch2_alone");
        idle();
        set_ch(0, 50, 60, 1'b1);
        set_ch(1, 50, 60, 1'b1);
        frame();
        pix(60, 40, 1'b1, 0, 10, 8, 1162, "t2_ch0_wins");

        // Top clamp on ch3
        idle();
        for (int k = 0; k < 3; k++) set_ch(k, 50, 60, 1'b0);
        set_ch(3, 300, 10, 1'b1);
        frame();
        pix(300, 0, 1'b1, 3, 0, 0, 12096, "t3_clamp_top");
        pix(300, 27, 1'b1, 3, 0, 27, 15984, "t3_clamp_last_row");
        miss(300, 28, "t3_row28_out");
        miss(299, 0, "t3_left_out");
        pix(443, 0, 1'b1, 3, 143, 0, 12239, "t3_right_col");
        miss(444, 0, "t3_right_out");
        idle();
        set_ch(3, 300, 28, 1'b1);
        frame();
        pix(301, 27, 1'b1, 3, 1, 27, 15985, "t3_boxy_eq_h");
        miss(301, 28, "t3_boxy_eq_h_out");
        idle();
        set_ch(3, 300, 29, 1'b1);
        frame();
        miss(300, 0, "t3_top1_row0");
        pix(300, 1, 1'b1, 3, 0, 0, 12096, "t3_top1_row1");
        pix(300, 28, 1'b1, 3, 0, 27, 15984, "t3_top1_row28");
        miss(300, 29, "t3_top1_row29");

        // All channels disabled over a scan covering every configured label
        idle();
        set_ch(0, 100, 200, 1'b0);
        set_ch(1, 50, 60, 1'b0);
        set_ch(2, 50, 60, 1'b0);
        set_ch(3, 300, 10, 1'b0);
        frame();
        for (int v = 0; v < 200; v += 9)
            for (int h = 40; h < 460; h += 13)
                miss(h, v, "t4_disabled");

        // Reset in the middle of a label flushes everything in flight
        idle();
        set_ch(0, 100, 200, 1'b1);
        frame();
        pix(148, 180, 1'b1, 0, 48, 8, 1200, "t4_pre_rst_a");
        pix(149, 180, 1'b1, 0, 49, 8, 1201, "t4_pre_rst_b");
        pix(150, 180, 1'b1, 0, 50, 8, 1202, "t4_flushed_a");
        pix(151, 180, 1'b1, 0, 51, 8, 1203, "t4_flushed_b");
        pix(152, 180, 1'b1, 0, 52, 8, 1204, "t4_flushed_c");
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
        set_ch(0, 100, 200, 1'b1);
        frame();
        pix(152, 180, 1'b1, 0, 52, 8, 1204, "t4_post_rst");

        // Right edge near the counter limit: no wrap into low columns
        idle();
        set_ch(0, 4000, 100, 1'b1);
        frame();
        pix(4000, 72, 1'b1, 0, 0, 0, 0, "t5_left");
        pix(4095, 72, 1'b1, 0, 95, 0, 95, "t5_last_col");
        pix(4095, 99, 1'b1, 0, 95, 27, 3983, "t5_last_corner");
        miss(3999, 72, "t5_left_out");
        miss(4000, 71, "t5_top_out");
        miss(4000, 100, "t5_bottom_out");
        for (int h = 0; h < 48; h++) miss(h, 80, "t5_no_wrap");

`ifdef OSD_FRAME_LATCH_EN
        // Box moved mid-frame stays put until the next frame start
        idle();
        set_ch(0, 100, 200, 1'b1);
        frame();
        pix(100, 172, 1'b1, 0, 0, 0, 0, "t6_old_pos");
        idle();
        set_ch(0, 500, 200, 1'b1);
        idle();
        idle();
        pix(100, 172, 1'b1, 0, 0, 0, 0, "t6_held");
        miss(500, 172, "t6_new_not_yet");
        frame();
        pix(500, 172, 1'b1, 0, 0, 0, 0, "t6_new_pos");
        miss(100, 172, "t6_old_gone");
`endif

        repeat (3) idle();
        repeat (4) @(posedge clk);
        #1;
        end_chk = 1'b1;
        @(posedge clk);
        #1;
        end_chk = 1'b0;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
